wb_stream_dma_reader: RTL

Parametrised Wishbone-to-stream reader, successor to the fixed-configuration stream writer. It fetches a memory buffer with Wishbone incrementing bursts into an internal first-word-fall-through FIFO and presents the words on a valid/ready stream. It adds one-shot and circular (ring-buffer) modes, stop requests, error abort, completion pulses and FIFO-level status. It sits between system memory and a streaming consumer such as a DAC or packet sink.

---
 rtl/wb_stream_dma_reader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/wb_stream_dma_reader.sv
// Wishbone burst reader: fetches a memory buffer into a first-word-fall-through FIFO
// and presents it as a valid/ready stream. Supports one-shot or circular passes.
//
// state | meaning
// IDLE  | waiting for start_i
// WAIT  | waiting until the FIFO has room for the next burst
// BURST | incrementing Wishbone burst in flight
// ERROR | bus error seen, waiting for start_i to clear err_o
module wb_stream_dma_reader #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WB_AW-1:0]               cfg_start_adr_i,
    input  logic [WB_AW-1:0]               cfg_buf_words_i,
    input  logic [$clog2(MAX_BURST_LEN):0] cfg_burst_words_i,
    input  logic                           cfg_circular_i,
    input  logic                           start_i,
    input  logic                           stop_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [FIFO_AW:0]               fifo_level_o,
    output logic [WB_AW-1:0]               wbm_adr_o,
    output logic [WB_DW-1:0]               wbm_dat_o,
    output logic [WB_DW/8-1:0]             wbm_sel_o,
    output logic                           wbm_we_o,
    output logic                           wbm_cyc_o,
    output logic                           wbm_stb_o,
    output logic [2:0]                     wbm_cti_o,
    output logic [1:0]                     wbm_bte_o,
    input  logic [WB_DW-1:0]               wbm_dat_i,
    input  logic                           wbm_ack_i,
    input  logic                           wbm_err_i,
    input  logic                           wbm_rty_i,
    output logic [WB_DW-1:0]               stream_data_o,
    output logic                           stream_valid_o,
    input  logic                           stream_ready_i
);
    localparam int WSB  = WB_DW / 8;
    localparam int BL_W = $clog2(MAX_BURST_LEN) + 1;
    localparam logic [FIFO_AW:0]  DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [WB_AW-1:0]  ADR_INC = WB_AW'(WSB);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, ERROR} state_t;

    state_t             state, state_nx;
    logic [WB_AW-1:0]   start_l, buf_l, adr, rem;
    logic [BL_W-1:0]    burst_l, beat, len;
    logic               circ_l, stop_pend;
    logic [WB_DW-1:0]   mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level, free;
    logic               in_burst, beat_ok, last_beat, pass_end, stop_req, space_ok, push, pop;

    assign in_burst  = (state == BURST);
    assign len       = (rem < WB_AW'(burst_l)) ? rem[BL_W-1:0] : burst_l;
    assign free      = DEPTH - level;
    // Room for the whole burst is reserved up front, so a burst can never overflow.
    assign space_ok  = 32'(free) >= 32'(len);
    assign beat_ok   = wbm_ack_i && !wbm_err_i && !wbm_rty_i;
    assign last_beat = (beat == len - BL_W'(1));
    assign pass_end  = (rem == WB_AW'(len));
    assign stop_req  = stop_pend || stop_i;
    assign push      = in_burst && beat_ok;
    assign pop       = stream_valid_o && stream_ready_i;

    assign busy_o         = (state == WAIT) || in_burst;
    assign wbm_cyc_o      = in_burst;
    assign wbm_stb_o      = in_burst;
    assign wbm_cti_o      = !in_burst ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
    assign wbm_adr_o      = adr;
    assign wbm_dat_o      = '0;
    assign wbm_sel_o      = '1;
    assign wbm_we_o       = 1'b0;
    assign wbm_bte_o      = 2'b00;
    assign fifo_level_o   = level;
    assign stream_valid_o = (level != '0);
    assign stream_data_o  = stream_valid_o ? mem[rd_ptr] : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_i && cfg_buf_words_i != '0) state_nx = WAIT;
            end
            WAIT: begin
                if (stop_i)        state_nx = IDLE;
                else if (space_ok) state_nx = BURST;
            end
            BURST: begin
                if (wbm_err_i) begin
                    state_nx = ERROR;
                end else if (beat_ok && last_beat) begin
                    if (stop_req || (pass_end && !circ_l)) state_nx = IDLE;
                    else                                   state_nx = WAIT;
                end
            end
            ERROR: begin
                if (start_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_l   <= '0;
            buf_l     <= '0;
            burst_l   <= '0;
            circ_l    <= 1'b0;
            adr       <= '0;
            rem       <= '0;
            beat      <= '0;
            stop_pend <= 1'b0;
            err_o     <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        start_l   <= cfg_start_adr_i;
                        buf_l     <= cfg_buf_words_i;
                        burst_l   <= cfg_burst_words_i;
                        circ_l    <= cfg_circular_i;
                        adr       <= cfg_start_adr_i;
                        rem       <= cfg_buf_words_i;
                        beat      <= '0;
                        stop_pend <= 1'b0;
                        err_o     <= 1'b0;
                        done_o    <= (cfg_buf_words_i == '0);
                    end
                end
                BURST: begin
                    if (stop_i) stop_pend <= 1'b1;
                    if (wbm_err_i) begin
                        err_o <= 1'b1;
                        beat  <= '0;
                    end else if (beat_ok) begin
                        if (last_beat) begin
                            beat <= '0;
                            // A stopped pass ends silently, even if it was the final burst.
                            if (pass_end) done_o <= !stop_req;
                            if (pass_end && circ_l) begin
                                adr <= start_l;
                                rem <= buf_l;
                            end else begin
                                adr <= adr + ADR_INC;
                                rem <= rem - WB_AW'(len);
                            end
                        end else begin
                            adr  <= adr + ADR_INC;
                            beat <= beat + BL_W'(1);
                        end
                    end
                end
                ERROR: begin
                    if (start_i) err_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            level <= level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wbm_dat_i;
    end
endmodule
